// File: rtl/lives_manager_if.sv
// Status bus between the lives tracker and its consumers (score logic, display, game controller).
interface lives_manager_if #(
    parameter int MAX_LIVES = 5
);
    logic [3:0]           level;
    logic [MAX_LIVES-1:0] lives;
    logic [2:0]           lives_left;
    logic [2:0]           lives_lost;
    logic                 last_life;
    logic                 game_over;
    logic [1:0]           state;
    logic [1:0]           shields_used;

    modport master (
        output level,
        input  lives, lives_left, lives_lost, last_life, game_over, state, shields_used
    );

    modport slave (
        input  level,
        output lives, lives_left, lives_lost, last_life, game_over, state, shields_used
    );
endinterface

// File: rtl/lives_manager.sv
// Remaining-lives tracker: one clk_lives edge per missed ball, thermometer/flag outputs.
// Optional shield (absorbed miss per SHIELD_STEP levels gained) enabled by `define EXTRA_LIFE_EN.
module lives_manager #(
    parameter int MAX_LIVES   = 5,
    parameter int LIVES_INIT  = 5,
    parameter int SHIELD_STEP = 3
) (
    input logic           clk_lives,
    input logic           reset,
    lives_manager_if.slave bus
);
    localparam logic [1:0] ST_PLAY = 2'd0;
    localparam logic [1:0] ST_LAST = 2'd1;
    localparam logic [1:0] ST_OVER = 2'd2;

    localparam bit PARAMS_OK = (MAX_LIVES >= 1) && (MAX_LIVES <= 7) &&
                               (LIVES_INIT >= 1) && (LIVES_INIT <= MAX_LIVES) &&
                               (SHIELD_STEP >= 1) && (SHIELD_STEP <= 15);

    if (!PARAMS_OK) begin : g_bad_params
        $error("lives_manager: parameter out of legal range");
    end

    localparam logic [MAX_LIVES-1:0] LIVES_RST  = {MAX_LIVES{1'b1}} >> (MAX_LIVES - LIVES_INIT);
    localparam logic [2:0]           LEFT_RST   = LIVES_INIT[2:0];
    localparam logic [1:0]           STATE_RST  = (LIVES_INIT == 1) ? ST_LAST : ST_PLAY;

    logic [1:0]           state_q, state_d;
    logic [MAX_LIVES-1:0] lives_q, lives_d;
    logic [2:0]           lives_left_q, lives_left_d;
    logic [2:0]           lives_lost_q, lives_lost_d;
    logic                 miss_edge;
    logic                 shield_hit;

    assign miss_edge = (bus.level != 4'd0);

`ifdef EXTRA_LIFE_EN
    localparam logic [4:0] STEP5 = SHIELD_STEP[4:0];

    logic [3:0] granted_level_q, granted_level_d;
    logic [1:0] shields_q, shields_d;

    // Threshold is formed in 5 bits so granted_level near 15 cannot wrap into a false hit.
    assign shield_hit = miss_edge && ((state_q == ST_PLAY) || (state_q == ST_LAST)) &&
                        ({1'b0, bus.level} >= ({1'b0, granted_level_q} + STEP5));

    always_comb begin
        granted_level_d = granted_level_q;
        shields_d       = shields_q;
        if (shield_hit) begin
            granted_level_d = granted_level_q + STEP5[3:0];
            if (shields_q != 2'd3) shields_d = shields_q + 2'd1;
        end
    end

    always_ff @(posedge clk_lives or posedge reset) begin
        if (reset) begin
            granted_level_q <= '0;
            shields_q       <= '0;
        end else begin
            granted_level_q <= granted_level_d;
            shields_q       <= shields_d;
        end
    end

    assign bus.shields_used = shields_q;
`else
    assign shield_hit       = 1'b0;
    assign bus.shields_used = '0;
`endif

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        lives_left_d = lives_left_q;
        lives_lost_d = lives_lost_q;
        if (miss_edge && !shield_hit) begin
            case (state_q)
                ST_PLAY: begin
                    if (lives_left_q != 3'd0) lives_left_d = lives_left_q - 3'd1;
                    lives_d = lives_q >> 1;
                    if (lives_lost_q != 3'd7) lives_lost_d = lives_lost_q + 3'd1;
                    if (lives_left_q == 3'd2) state_d = ST_LAST;
                end
                ST_LAST: begin
                    lives_left_d = '0;
                    lives_d      = '0;
                    if (lives_lost_q != 3'd7) lives_lost_d = lives_lost_q + 3'd1;
                    state_d      = ST_OVER;
                end
                ST_OVER: begin
                end
                default: state_d = ST_OVER;
            endcase
        end
    end

    always_ff @(posedge clk_lives or posedge reset) begin
        if (reset) begin
            state_q      <= STATE_RST;
            lives_q      <= LIVES_RST;
            lives_left_q <= LEFT_RST;
            lives_lost_q <= '0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            lives_left_q <= lives_left_d;
            lives_lost_q <= lives_lost_d;
        end
    end

    assign bus.lives      = lives_q;
    assign bus.lives_left = lives_left_q;
    assign bus.lives_lost = lives_lost_q;
    assign bus.state      = state_q;
    assign bus.last_life  = (state_q == ST_LAST);
    assign bus.game_over  = (state_q == ST_OVER);
endmodule

// File: tb/tb_lives_manager.sv
// Directed scoreboard bench for lives_manager (default and single-life builds).
module tb_lives_manager;
    logic clk_lives;
    logic reset;

    lives_manager_if #(.MAX_LIVES(5)) bus0 ();
    lives_manager_if #(.MAX_LIVES(5)) bus1 ();

    lives_manager #(.MAX_LIVES(5), .LIVES_INIT(5), .SHIELD_STEP(3)) dut (
        .clk_lives (clk_lives),
        .reset     (reset),
        .bus       (bus0.slave)
    );

    lives_manager #(.MAX_LIVES(5), .LIVES_INIT(1), .SHIELD_STEP(3)) dut1 (
        .clk_lives (clk_lives),
        .reset     (reset),
        .bus       (bus1.slave)
    );

    typedef struct {
        string      tag;
        logic [4:0] lives;
        logic [2:0] left;
        logic [2:0] lost;
        logic       last_life;
        logic       over;
        logic [1:0] st;
        logic [1:0] sh;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_left, m_lost, m_state, m_shields, m_granted;

    function automatic logic [4:0] therm(input int n);
        logic [4:0] t;
        for (int i = 0; i < 5; i++) t[i] = (n > i);
        return t;
    endfunction

    task automatic model_reset();
        m_left = 5; m_lost = 0; m_state = 0; m_shields = 0; m_granted = 0;
    endtask

    task automatic model_edge(input int lvl);
        if (lvl == 0 || m_state == 2) return;
`ifdef EXTRA_LIFE_EN
        if (lvl >= m_granted + 3) begin
            m_granted += 3;
            if (m_shields < 3) m_shields++;
            return;
        end
`endif
        if (m_left > 0) m_left--;
        if (m_lost < 7) m_lost++;
        if (m_left == 0)      m_state = 2;
        else if (m_left == 1) m_state = 1;
        else                  m_state = 0;
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag       = tag;
        e.lives     = therm(m_left);
        e.left      = m_left[2:0];
        e.lost      = m_lost[2:0];
        e.last_life = (m_state == 1);
        e.over      = (m_state == 2);
        e.st        = m_state[1:0];
        e.sh        = m_shields[1:0];
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pop_and_check();
        exp_t e;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".lives"},        32'(bus0.lives),        32'(e.lives));
        chk({e.tag, ".lives_left"},   32'(bus0.lives_left),   32'(e.left));
        chk({e.tag, ".lives_lost"},   32'(bus0.lives_lost),   32'(e.lost));
        chk({e.tag, ".last_life"},    32'(bus0.last_life),    32'(e.last_life));
        chk({e.tag, ".game_over"},    32'(bus0.game_over),    32'(e.over));
        chk({e.tag, ".state"},        32'(bus0.state),        32'(e.st));
        chk({e.tag, ".shields_used"}, 32'(bus0.shields_used), 32'(e.sh));
    endtask

    task automatic miss(input int lvl, input string tag);
        bus0.level = lvl[3:0];
        bus1.level = lvl[3:0];
        #2;
        model_edge(lvl);
        push_exp(tag);
        clk_lives = 1'b1;
        #2;
        pop_and_check();
        #3;
        clk_lives = 1'b0;
        #3;
    endtask

    task automatic do_reset(input string tag);
        #1;
        reset = 1'b1;
        model_reset();
        push_exp(tag);
        #1;
        pop_and_check();
        #2;
        reset = 1'b0;
        #2;
    endtask

    initial begin
        clk_lives  = 1'b0;
        reset      = 1'b0;
        bus0.level = 4'd0;
        bus1.level = 4'd0;

        do_reset("rst0");
        chk("init1.state",     32'(bus1.state),     32'd1);
        chk("init1.last_life", 32'(bus1.last_life), 32'd1);
        chk("init1.lives",     32'(bus1.lives),     32'h01);
        chk("init1.left",      32'(bus1.lives_left), 32'd1);

        for (int i = 0; i < 4; i++) miss(1, "drain");
        miss(1, "final");
        for (int i = 0; i < 3; i++) miss(1, "over_hold");
        miss(15, "over_lvl15");

        do_reset("rst1");
        for (int i = 0; i < 3; i++) miss(0, "idle");
        miss(2, "lvl2");

        do_reset("rst2");
        miss(1, "pre_rst_a");
        miss(1, "pre_rst_b");
        do_reset("mid_rst");

`ifdef EXTRA_LIFE_EN
        miss(3, "shield1");
        miss(3, "no_shield");
        miss(6, "shield2");
        for (int i = 0; i < 8 && m_state != 2; i++) miss(6, "to_over");
        miss(15, "over_no_shield");
`else
        miss(3, "lvl3");
        miss(6, "lvl6");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
